draw_slice_column: RTL and testbench

DRAW_SLICE_COLUMN -- requirements
Module: draw_slice_column

---
 rtl/draw_slice_column_if.sv | 33 +++
 rtl/draw_slice_column.sv | 169 ++++++++++++++++
 tb/tb_draw_slice_column.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/draw_slice_column_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : draw_slice_column_if
//  Purpose  : Bundle of the column-draw request and the VGA pixel-write
//             signals shared by draw_slice_column and its requester.
//  Signals  : start, column, slice_size   (requester -> drawer)
//             x, y, colour, plot          (drawer -> VGA adapter)
//             busy, done                  (drawer status)
//  Revision : 1.0  initial release
// ============================================================================
interface draw_slice_column_if;
    logic       start;
    logic [7:0] column;
    logic [6:0] slice_size;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, column, slice_size,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, column, slice_size,
        output x, y, colour, plot, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/draw_slice_column.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : draw_slice_column
//  Purpose  : Paints one full screen column: ceiling rows above a centred
//             wall slice, wall rows, then floor rows, one pixel per clock.
//  Ports    : clk_i  - sole clock, rising edge
//             rst_i  - synchronous active-high reset
//             bus    - draw_slice_column_if.slave (start/column/slice_size in,
//                      x/y/colour/plot/busy/done out)
//  Revision : 1.0  initial release
// ============================================================================
module draw_slice_column #(
    parameter int unsigned SCREEN_H     = 120,
    parameter int unsigned SCREEN_W     = 160,
    parameter logic [2:0]  CEIL_COLOUR  = 3'b001,
    parameter logic [2:0]  WALL_COLOUR  = 3'b111,
    parameter logic [2:0]  FLOOR_COLOUR = 3'b010
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    draw_slice_column_if.slave  bus
);

    localparam logic [6:0] ROWS = 7'(SCREEN_H);
    localparam logic [8:0] COLS = 9'(SCREEN_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q,  state_d;
    logic [7:0] col_q,    col_d;
    logic [6:0] slice_q,  slice_d;
    logic [6:0] top_q,    top_d;
    logic [6:0] bottom_q, bottom_d;
    logic [6:0] row_q,    row_d;
    logic       hold_q,   hold_d;
    logic [7:0] x_q,      x_d;
    logic [6:0] y_q,      y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q,   plot_d;

    logic [6:0] h_w;
    logic [6:0] top_w;
    logic [6:0] bottom_w;
    logic       in_range_w;

    function automatic logic [2:0] row_colour(input logic [6:0] row,
                                              input logic [6:0] top,
                                              input logic [6:0] bottom);
        if (row < top)
            return CEIL_COLOUR;
        else if (row < bottom)
            return WALL_COLOUR;
        else
            return FLOOR_COLOUR;
    endfunction

    // Slice geometry from the captured height; top rounds down so an odd
    // height leaves its extra row on the floor side.
    always_comb begin
        h_w        = (slice_q > ROWS) ? ROWS : slice_q;
        top_w      = (ROWS - h_w) >> 1;
        bottom_w   = top_w + h_w;
        in_range_w = ({1'b0, col_q} < COLS);
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        slice_d  = slice_q;
        top_d    = top_q;
        bottom_d = bottom_q;
        row_d    = row_q;
        hold_d   = hold_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    col_d   = bus.column;
                    slice_d = bus.slice_size;
                    hold_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                top_d    = top_w;
                bottom_d = bottom_w;
                if (in_range_w) begin
                    // Row 0 is issued from here using the freshly computed
                    // bounds so the first pixel appears on the next cycle.
                    x_d      = col_q;
                    y_d      = 7'd0;
                    colour_d = row_colour(7'd0, top_w, bottom_w);
                    plot_d   = 1'b1;
                    row_d    = 7'd1;
                    state_d  = S_DRAW;
                end else if (hold_q) begin
                    state_d = S_DONE;
                end else begin
                    // Rejected columns linger one extra cycle so done still
                    // arrives a fixed three cycles after start.
                    hold_d = 1'b1;
                end
            end
            S_DRAW: begin
                if (row_q < ROWS) begin
                    y_d      = row_q;
                    colour_d = row_colour(row_q, top_q, bottom_q);
                    plot_d   = 1'b1;
                    row_d    = row_q + 7'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                row_d   = 7'd0;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            col_q    <= 8'd0;
            slice_q  <= 7'd0;
            top_q    <= 7'd0;
            bottom_q <= 7'd0;
            row_q    <= 7'd0;
            hold_q   <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            slice_q  <= slice_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
            row_q    <= row_d;
            hold_q   <= hold_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_draw_slice_column.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_draw_slice_column
//  Purpose  : Self-checking bench for draw_slice_column. Directed columns with
//             hand-derived slice bounds feed an expected-pixel queue; a
//             monitor pops and compares on every plot strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_draw_slice_column;

    localparam logic [2:0] C_CEIL  = 3'b001;
    localparam logic [2:0] C_WALL  = 3'b111;
    localparam logic [2:0] C_FLOOR = 3'b010;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } px_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    px_t  exp_q[$];

    draw_slice_column_if bus ();

    draw_slice_column dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every plotted pixel must match the head of the expected queue.
    always @(negedge clk) begin
        px_t p;
        if (bus.plot === 1'b1) begin
            check("plot_done_overlap", {31'd0, bus.done}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_plot actual=x%0d,y%0d required=no plot", bus.x, bus.y);
            end else begin
                p = exp_q.pop_front();
                check("pix_x",      {24'd0, bus.x},      {24'd0, p.x});
                check("pix_y",      {25'd0, bus.y},      {25'd0, p.y});
                check("pix_colour", {29'd0, bus.colour}, {29'd0, p.colour});
            end
        end
    end

    task automatic push_column(input logic [7:0] col, input int top, input int bot);
        for (int r = 0; r < 120; r++) begin
            px_t p;
            p.x      = col;
            p.y      = r[6:0];
            p.colour = (r < top) ? C_CEIL : ((r < bot) ? C_WALL : C_FLOOR);
            exp_q.push_back(p);
        end
    endtask

    // top/bot are the hand-derived wall bounds; perturb fires stray starts
    // with different inputs at cycles 10 and 60.
    task automatic run_column(input logic [7:0] col, input logic [6:0] sl,
                              input int top, input int bot, input bit perturb);
        bit inr;
        int dc;
        inr = (col < 8'd160);
        if (inr) push_column(col, top, bot);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.column     = col;
        bus.slice_size = sl;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.column     = 8'hAA;
        bus.slice_size = 7'h55;
        dc = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) check("busy_cycle1", {31'd0, bus.busy}, 32'd1);
            if (n == 2) check("plot_cycle2", {31'd0, bus.plot}, {31'd0, inr});
            if (perturb && (n == 10 || n == 60)) begin
                bus.start      = 1'b1;
                bus.column     = 8'd99;
                bus.slice_size = 7'd3;
            end else if (perturb && (n == 11 || n == 61)) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                dc = n;
                break;
            end
        end
        check("done_cycle", dc, inr ? 32'd122 : 32'd3);
        @(negedge clk);
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
        check("done_one_cycle",  {31'd0, bus.done}, 32'd0);
        check("queue_drained",   exp_q.size(), 32'd0);
    endtask

    task automatic reset_mid_draw();
        int done_seen;
        push_column(8'd40, 40, 80);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.column     = 8'd40;
        bus.slice_size = 7'd40;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 50; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_plot", {31'd0, bus.plot}, 32'd0);
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        // Rows that were never drawn are abandoned.
        exp_q.delete();
        done_seen = 0;
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("rst_no_done", done_seen, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.column     = 8'd0;
        bus.slice_size = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_x",      {24'd0, bus.x},      32'd0);
        check("reset_y",      {25'd0, bus.y},      32'd0);
        check("reset_colour", {29'd0, bus.colour}, 32'd0);
        check("reset_plot",   {31'd0, bus.plot},   32'd0);
        check("reset_busy",   {31'd0, bus.busy},   32'd0);
        check("reset_done",   {31'd0, bus.done},   32'd0);

        // start coincident with reset must be dropped
        bus.start      = 1'b1;
        bus.column     = 8'd5;
        bus.slice_size = 7'd40;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("start_under_reset", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {31'd0, bus.busy}, 32'd0);

        run_column(8'd5,   7'd40,  40, 80,  1'b0);
        run_column(8'd7,   7'd0,   60, 60,  1'b0);
        run_column(8'd9,   7'd127, 0,  120, 1'b0);
        run_column(8'd11,  7'd41,  39, 80,  1'b0);
        run_column(8'd13,  7'd1,   59, 60,  1'b0);
        run_column(8'd159, 7'd120, 0,  120, 1'b0);
        run_column(8'd160, 7'd40,  0,  0,   1'b0);
        run_column(8'd255, 7'd10,  0,  0,   1'b0);
        run_column(8'd20,  7'd40,  40, 80,  1'b1);
        reset_mid_draw();
        run_column(8'd30,  7'd64,  28, 92,  1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
